arc4_core: RTL and testbench
============================

# arc4_core

Parametrised single-FSM ARC4 decryption engine for the cracking datapath. It generalises the fixed 24-bit, three-submodule decryptor: key length is a parameter, and the init, key-schedule and keystream phases are merged into one controller that owns the S array directly. It adds an on-the-fly printable-ASCII check with optional early abort, so a key search can discard a wrong key without waiting for the full message. It reads a length-prefixed ciphertext memory and writes a length-prefixed plaintext memory.

## Interface
- KEY_BYTES, 3, key length in bytes (1..32); key width is 8*KEY_BYTES.
- CHECK_ASCII, 1, when 1, key_ok reports whether every plaintext byte is in 0x20..0x7E; when 0, key_ok is 1 after every completed run.
- STOP_ON_BAD, 1, when 1 and CHECK_ASCII=1, the run aborts right after the first non-printable byte is written.
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  start request; accepted only in the cycle where rdy=1.
- rdy  output  1  idle/ready; result valid when 1.
- key  input  8*KEY_BYTES  key; byte 0 is key[8*KEY_BYTES-1 -: 8]; latched on accept.
- ct_addr  output  8  ciphertext memory address.
- ct_rddata  input  8  ciphertext data; 1-cycle sync read latency.
- pt_addr  output  8  plaintext memory address.
- pt_wrdata  output  8  plaintext write data.
- pt_wren  output  1  plaintext write strobe.
- key_ok  output  1  run verdict; held from run end until next accept.

## Operation
- FSM states (arc4_pkg): IDLE, INIT, KSA_RI, KSA_RJ, KSA_WJ, KSA_WI, LEN_RD, LEN_WR, P_RI, P_RJ, P_WI, P_WJ, P_PAD, P_WR, DONE.
- IDLE: rdy=1. On en=1, latch key, clear key_ok, clear i/j/k, and go to INIT.
- INIT: for i=0..255, write S[i]=i (256 cycles).
- KSA: for i=0..255, j=(j+S[i]+key[i mod KEY_BYTES]) mod 256, then swap S[i] and S[j]. Four states per i: RI, RJ, WJ, WI.
- LEN_RD/LEN_WR: len=ct[0], then write pt[0]=len. If len=0, go to DONE with key_ok=1.
- PRGA: for k=1..len:
  - i=i+1, j=j+S[i], swap S[i] and S[j];
  - pad=S[(S[i]+S[j]) mod 256];
  - write pt[k]=pad^ct[k];
  - ct[k] is fetched during P_RI.
- ASCII check is applied to each pt[k]. On a bad byte: key_ok is forced 0 at run end. With STOP_ON_BAD=1, go P_WR→DONE immediately.
- All index arithmetic is 8-bit and wraps mod 256.
- DONE: one cycle with key_ok settled, then IDLE.
- en while rdy=0 is ignored. Key changes after accept are ignored.
- Reset in any state: next cycle IDLE, rdy=1, pt_wren=0, key_ok=0. S contents are undefined and always rebuilt by INIT.

## Timing
- Reset values: rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0, key_ok=0.
- Memory reads: address is presented in cycle n, data is used in cycle n+1. Read-during-write behaviour of S is never relied on.
- Phase costs:
  - INIT: 256 cycles.
  - KSA: 4 cycles per i, 1024 cycles total.
  - LEN: 2 cycles.
  - PRGA: 6 cycles per byte.
  - DONE: 1 cycle.
- Total: exactly 1283+6*len cycles from the accept edge to rdy=1 for a full run.
- pt_wren is a single-cycle strobe per byte; exactly len+1 writes occur per full run.
- rdy drops the cycle after accept and rises the cycle after DONE.
- key_ok is stable whenever rdy=1.
- en held high restarts a run on the first rdy=1 cycle.

## Structure
- arc4_pkg holds:
  - the state_t enum;
  - S_DEPTH=256;
  - ASCII_LO=8'h20 and ASCII_HI=8'h7E;
  - phase cycle constants for the bench.
- Sub-module arc4_s_ram: 256x8 single-port synchronous RAM with 1-cycle read latency, driven only by arc4_core.

## Test plan
- Reset: assert rst_n=0 for 2 cycles -> rdy=1, pt_wren=0, key_ok=0. en=0 for 100 cycles -> no pt writes.
- KEY_BYTES=3, key=24'h4B6579 ("Key"), ct={09,BB,F3,16,E8,D9,40,AF,0A,D3} -> pt={09,"Plaintext"}, key_ok=1, rdy after 1283+54 cycles.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki"), ct={05,10,21,BF,04,20} -> pt={05,"pedia"}, key_ok=1.
- KEY_BYTES=6, key="Secret", ct={0E,45,A0,1F,64,5F,C3,5B,38,35,52,54,4B,9B,F5} -> pt={0E,"Attack at dawn"}, key_ok=1.
- Wrong key with the "Key" vector, key=24'h4B6578, STOP_ON_BAD=1 -> key_ok=0, and fewer than 10 writes whenever the first decrypted byte is non-printable. With STOP_ON_BAD=0 -> exactly 10 writes.
- ct[0]=0 -> single write pt[0]=0, key_ok=1, latency 1283.
- rst_n pulse mid-KSA, then a new en with the "Key" vector -> correct result. en pulses during busy -> ignored.

Source files
------------

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 decryption engine.
//   state_t       controller states
//   S_DEPTH       size of the ARC4 permutation array
//   ASCII_LO/HI   printable range used by the plaintext check
//   *_CYCLES      phase costs, so a bench can predict run latency
package arc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RI,
        KSA_RJ,
        KSA_WJ,
        KSA_WI,
        LEN_RD,
        LEN_WR,
        P_RI,
        P_RJ,
        P_WI,
        P_WJ,
        P_PAD,
        P_WR,
        DONE
    } state_t;

    localparam int S_DEPTH = 256;

    localparam logic [7:0] ASCII_LO = 8'h20;
    localparam logic [7:0] ASCII_HI = 8'h7E;

    localparam int INIT_CYCLES     = 256;
    localparam int KSA_CYCLES      = 1024;
    localparam int LEN_CYCLES      = 2;
    localparam int PRGA_BYTE_CYCLES = 6;
    localparam int DONE_CYCLES     = 1;
    localparam int RUN_BASE_CYCLES = INIT_CYCLES + KSA_CYCLES + LEN_CYCLES + DONE_CYCLES;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

// File: rtl/arc4_s_ram.sv
// arc4_s_ram: 256x8 single-port synchronous RAM holding the ARC4 S array.
//   clk     clock
//   addr    read/write address
//   wrdata  write data
//   wren    write enable
//   rddata  registered read data (valid the cycle after addr is presented)
module arc4_s_ram
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] wrdata,
    input  logic       wren,
    output logic [7:0] rddata
);

    logic [7:0] mem [S_DEPTH];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

endmodule

// File: rtl/arc4_core.sv
// arc4_core: single-controller ARC4 decryptor with printable-ASCII verdict.
//   clk, rst_n       clock, synchronous active-low reset
//   en / rdy         start request / idle-and-result-valid
//   key              key, byte 0 in the top byte, latched on accept
//   ct_addr/ct_rddata  length-prefixed ciphertext memory (1-cycle read)
//   pt_addr/pt_wrdata/pt_wren  length-prefixed plaintext memory write port
//   key_ok           verdict of the last run, held until the next accept
module arc4_core
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES   = 3,
    parameter int CHECK_ASCII = 1,
    parameter int STOP_ON_BAD = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren,
    output logic                   key_ok
);

    localparam bit         CHECK     = (CHECK_ASCII != 0);
    localparam bit         STOP      = CHECK && (STOP_ON_BAD != 0);
    localparam logic [5:0] KIDX_LAST = 6'(KEY_BYTES - 1);

    state_t                 state_reg, state_next;
    logic [7:0]             i_reg, i_next;
    logic [7:0]             j_reg, j_next;
    logic [7:0]             k_reg, k_next;
    logic [7:0]             len_reg, len_next;
    logic [7:0]             si_reg, si_next;
    logic [7:0]             sj_reg, sj_next;
    logic [7:0]             ct_reg, ct_next;
    logic [5:0]             kidx_reg, kidx_next;
    logic [8*KEY_BYTES-1:0] key_reg, key_next;
    logic                   bad_reg, bad_next;
    logic                   key_ok_reg, key_ok_next;

    logic [7:0] s_addr, s_wrdata, s_rddata;
    logic       s_wren;

    arc4_s_ram u_s_ram (
        .clk    (clk),
        .addr   (s_addr),
        .wrdata (s_wrdata),
        .wren   (s_wren),
        .rddata (s_rddata)
    );

    // Split the latched key into bytes, byte 0 taken from the top.
    logic [7:0] key_bytes [KEY_BYTES];
    generate
        for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_bytes
            assign key_bytes[gi] = key_reg[8*(KEY_BYTES-gi)-1 -: 8];
        end
    endgenerate

    logic [7:0] key_byte;
    always_comb begin
        key_byte = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (kidx_reg == 6'(n)) key_byte = key_bytes[n];
        end
    end

    logic [7:0] i_inc, j_ksa, j_prga, pt_byte;
    logic       bad_byte;
    assign i_inc    = i_reg + 8'd1;
    assign j_ksa    = j_reg + s_rddata + key_byte;
    assign j_prga   = j_reg + s_rddata;
    assign pt_byte  = s_rddata ^ ct_reg;
    assign bad_byte = CHECK && !is_printable(pt_byte);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            i_reg      <= 8'h00;
            j_reg      <= 8'h00;
            k_reg      <= 8'h00;
            len_reg    <= 8'h00;
            si_reg     <= 8'h00;
            sj_reg     <= 8'h00;
            ct_reg     <= 8'h00;
            kidx_reg   <= 6'd0;
            key_reg    <= '0;
            bad_reg    <= 1'b0;
            key_ok_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            i_reg      <= i_next;
            j_reg      <= j_next;
            k_reg      <= k_next;
            len_reg    <= len_next;
            si_reg     <= si_next;
            sj_reg     <= sj_next;
            ct_reg     <= ct_next;
            kidx_reg   <= kidx_next;
            key_reg    <= key_next;
            bad_reg    <= bad_next;
            key_ok_reg <= key_ok_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        i_next      = i_reg;
        j_next      = j_reg;
        k_next      = k_reg;
        len_next    = len_reg;
        si_next     = si_reg;
        sj_next     = sj_reg;
        ct_next     = ct_reg;
        kidx_next   = kidx_reg;
        key_next    = key_reg;
        bad_next    = bad_reg;
        key_ok_next = key_ok_reg;
        s_addr      = 8'h00;
        s_wrdata    = 8'h00;
        s_wren      = 1'b0;
        ct_addr     = 8'h00;
        pt_addr     = 8'h00;
        pt_wrdata   = 8'h00;
        pt_wren     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (en) begin
                    key_next    = key;
                    key_ok_next = 1'b0;
                    bad_next    = 1'b0;
                    i_next      = 8'h00;
                    j_next      = 8'h00;
                    k_next      = 8'h00;
                    kidx_next   = 6'd0;
                    state_next  = INIT;
                end
            end
            INIT: begin
                s_addr   = i_reg;
                s_wrdata = i_reg;
                s_wren   = 1'b1;
                i_next   = i_inc;
                if (i_reg == 8'hFF) state_next = KSA_RI;
            end
            KSA_RI: begin
                s_addr     = i_reg;
                state_next = KSA_RJ;
            end
            KSA_RJ: begin
                si_next    = s_rddata;
                j_next     = j_ksa;
                s_addr     = j_ksa;
                state_next = KSA_WJ;
            end
            KSA_WJ: begin
                // Capture S[j] before the swap overwrites it.
                sj_next    = s_rddata;
                s_addr     = j_reg;
                s_wrdata   = si_reg;
                s_wren     = 1'b1;
                state_next = KSA_WI;
            end
            KSA_WI: begin
                s_addr    = i_reg;
                s_wrdata  = sj_reg;
                s_wren    = 1'b1;
                i_next    = i_inc;
                kidx_next = (kidx_reg == KIDX_LAST) ? 6'd0 : kidx_reg + 6'd1;
                state_next = (i_reg == 8'hFF) ? LEN_RD : KSA_RI;
            end
            LEN_RD: begin
                ct_addr    = 8'h00;
                state_next = LEN_WR;
            end
            LEN_WR: begin
                len_next   = ct_rddata;
                pt_addr    = 8'h00;
                pt_wrdata  = ct_rddata;
                pt_wren    = 1'b1;
                i_next     = 8'h00;
                j_next     = 8'h00;
                k_next     = 8'h01;
                state_next = (ct_rddata == 8'h00) ? DONE : P_RI;
            end
            P_RI: begin
                i_next     = i_inc;
                s_addr     = i_inc;
                ct_addr    = k_reg;
                state_next = P_RJ;
            end
            P_RJ: begin
                si_next    = s_rddata;
                j_next     = j_prga;
                s_addr     = j_prga;
                ct_next    = ct_rddata;
                state_next = P_WI;
            end
            P_WI: begin
                sj_next    = s_rddata;
                s_addr     = i_reg;
                s_wrdata   = s_rddata;
                s_wren     = 1'b1;
                state_next = P_WJ;
            end
            P_WJ: begin
                s_addr     = j_reg;
                s_wrdata   = si_reg;
                s_wren     = 1'b1;
                state_next = P_PAD;
            end
            P_PAD: begin
                s_addr     = si_reg + sj_reg;
                state_next = P_WR;
            end
            P_WR: begin
                pt_addr   = k_reg;
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
                k_next    = k_reg + 8'd1;
                if (bad_byte) bad_next = 1'b1;
                if ((k_reg == len_reg) || (STOP && bad_byte)) state_next = DONE;
                else                                          state_next = P_RI;
            end
            DONE: begin
                key_ok_next = !bad_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rdy    = (state_reg == IDLE);
    assign key_ok = key_ok_reg;

endmodule

// File: tb/tb_arc4_core.sv
// tb_arc4_core: directed self-checking bench for arc4_core, four instances
// (3-byte key stop/no-stop, 4-byte key, 6-byte key) sharing clock and reset.
module tb_arc4_core;
    import arc4_pkg::*;

    logic clk;
    logic rst_n;
    logic [3:0] en;
    logic [3:0] rdy;
    logic [3:0] pt_we;
    logic [3:0] key_ok;
    logic [7:0] ct_addr [4];
    logic [7:0] ct_rd   [4];
    logic [7:0] pt_addr [4];
    logic [7:0] pt_wd   [4];
    logic [23:0] key0, key1;
    logic [31:0] key2;
    logic [47:0] key3;

    logic [7:0] ct_mem [4][256];
    logic [7:0] pt_mem [4][256];
    int         wr_cnt [4];

    int checks = 0;
    int errors = 0;

    logic [7:0] ct_key    [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] ct_wiki   [6]  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] ct_secret [15] = '{8'h0E, 8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                                   8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    logic [7:0] ref_pt [10];

    arc4_core #(.KEY_BYTES(3), .CHECK_ASCII(1), .STOP_ON_BAD(1)) u_k3s (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key0),
        .ct_addr(ct_addr[0]), .ct_rddata(ct_rd[0]), .pt_addr(pt_addr[0]),
        .pt_wrdata(pt_wd[0]), .pt_wren(pt_we[0]), .key_ok(key_ok[0]));
    arc4_core #(.KEY_BYTES(3), .CHECK_ASCII(1), .STOP_ON_BAD(0)) u_k3n (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key1),
        .ct_addr(ct_addr[1]), .ct_rddata(ct_rd[1]), .pt_addr(pt_addr[1]),
        .pt_wrdata(pt_wd[1]), .pt_wren(pt_we[1]), .key_ok(key_ok[1]));
    arc4_core #(.KEY_BYTES(4), .CHECK_ASCII(1), .STOP_ON_BAD(1)) u_k4 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .key(key2),
        .ct_addr(ct_addr[2]), .ct_rddata(ct_rd[2]), .pt_addr(pt_addr[2]),
        .pt_wrdata(pt_wd[2]), .pt_wren(pt_we[2]), .key_ok(key_ok[2]));
    arc4_core #(.KEY_BYTES(6), .CHECK_ASCII(1), .STOP_ON_BAD(1)) u_k6 (
        .clk(clk), .rst_n(rst_n), .en(en[3]), .rdy(rdy[3]), .key(key3),
        .ct_addr(ct_addr[3]), .ct_rddata(ct_rd[3]), .pt_addr(pt_addr[3]),
        .pt_wrdata(pt_wd[3]), .pt_wren(pt_we[3]), .key_ok(key_ok[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ciphertext ROMs (1-cycle registered read) and plaintext RAMs.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            ct_rd[n] <= ct_mem[n][ct_addr[n]];
            if (pt_we[n]) begin
                pt_mem[n][pt_addr[n]] <= pt_wd[n];
                wr_cnt[n] <= wr_cnt[n] + 1;
                $display("write inst=%0d addr=%0d data=%02h", n, pt_addr[n], pt_wd[n]);
            end
        end
    end

    initial begin
        for (int n = 0; n < 4; n++) wr_cnt[n] = 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept a run on instance n and count clock edges until rdy returns.
    // With disturb set, en is re-pulsed and key0 scrambled mid-run.
    task automatic run(input int n, input bit disturb, output int cycles);
        @(negedge clk);
        en[n] = 1'b1;
        @(posedge clk);
        #1;
        en[n] = 1'b0;
        check("rdy_drop", {31'd0, rdy[n]}, 32'd0);
        cycles = 0;
        while (!rdy[n] && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (disturb && cycles == 300) begin
                en[n] = 1'b1;
                key0  = 24'hFFFFFF;
            end else if (disturb && cycles == 301) begin
                en[n] = 1'b0;
            end
        end
        $display("run inst=%0d cycles=%0d key_ok=%0d writes=%0d", n, cycles, key_ok[n], wr_cnt[n]);
    endtask

    // Plain ARC4 reference over the "Key" ciphertext vector.
    task automatic rc4_ref(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] t, i, j;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j = j + s[a] + kb[a % 3];
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        ref_pt[0] = ct_key[0];
        for (int a = 1; a < 10; a++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            ref_pt[a] = s[t] ^ ct_key[a];
        end
    endtask

    initial begin
        int cyc, base, fb, exp_w;
        string s_plain, s_pedia, s_attack;
        s_plain  = "Plaintext";
        s_pedia  = "pedia";
        s_attack = "Attack at dawn";
        en    = 4'b0000;
        key0  = 24'h0;
        key1  = 24'h0;
        key2  = 32'h0;
        key3  = 48'h0;
        rst_n = 1'b0;
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 256; a++) ct_mem[n][a] = 8'h00;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            check("reset_rdy",    {31'd0, rdy[n]},    32'd1);
            check("reset_wren",   {31'd0, pt_we[n]},  32'd0);
            check("reset_key_ok", {31'd0, key_ok[n]}, 32'd0);
            check("reset_ct_addr", {24'd0, ct_addr[n]}, 32'd0);
            check("reset_pt_addr", {24'd0, pt_addr[n]}, 32'd0);
            check("reset_pt_data", {24'd0, pt_wd[n]},   32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("idle_no_writes", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3]), 32'd0);

        // "Key" / "Plaintext"
        for (int a = 0; a < 10; a++) ct_mem[0][a] = ct_key[a];
        key0 = 24'h4B6579;
        base = wr_cnt[0];
        run(0, 1'b0, cyc);
        check("key_cycles", 32'(cyc), 32'd1337);
        check("key_ok",     {31'd0, key_ok[0]}, 32'd1);
        check("key_writes", 32'(wr_cnt[0] - base), 32'd10);
        check("key_len",    {24'd0, pt_mem[0][0]}, 32'h09);
        for (int a = 1; a < 10; a++) check("key_pt", {24'd0, pt_mem[0][a]}, {24'd0, s_plain[a-1]});
        @(posedge clk);
        #1;
        check("key_ok_held", {31'd0, key_ok[0]}, 32'd1);

        // "Wiki" / "pedia"
        for (int a = 0; a < 6; a++) ct_mem[2][a] = ct_wiki[a];
        key2 = 32'h57696B69;
        base = wr_cnt[2];
        run(2, 1'b0, cyc);
        check("wiki_cycles", 32'(cyc), 32'd1313);
        check("wiki_ok",     {31'd0, key_ok[2]}, 32'd1);
        check("wiki_writes", 32'(wr_cnt[2] - base), 32'd6);
        for (int a = 1; a < 6; a++) check("wiki_pt", {24'd0, pt_mem[2][a]}, {24'd0, s_pedia[a-1]});

        // "Secret" / "Attack at dawn"
        for (int a = 0; a < 15; a++) ct_mem[3][a] = ct_secret[a];
        key3 = 48'h536563726574;
        base = wr_cnt[3];
        run(3, 1'b0, cyc);
        check("secret_cycles", 32'(cyc), 32'd1367);
        check("secret_ok",     {31'd0, key_ok[3]}, 32'd1);
        check("secret_writes", 32'(wr_cnt[3] - base), 32'd15);
        for (int a = 1; a < 15; a++) check("secret_pt", {24'd0, pt_mem[3][a]}, {24'd0, s_attack[a-1]});

        // Wrong key, early abort enabled
        rc4_ref(24'h4B6578);
        fb = 0;
        for (int a = 9; a >= 1; a--) if (!is_printable(ref_pt[a])) fb = a;
        exp_w = (fb != 0) ? fb + 1 : 10;
        key0 = 24'h4B6578;
        base = wr_cnt[0];
        run(0, 1'b0, cyc);
        check("bad_stop_ok",     {31'd0, key_ok[0]}, {31'd0, fb == 0});
        check("bad_stop_writes", 32'(wr_cnt[0] - base), 32'(exp_w));
        check("bad_stop_cycles", 32'(cyc), 32'(RUN_BASE_CYCLES + 6 * (exp_w - 1)));
        check("bad_stop_last",   {24'd0, pt_mem[0][exp_w-1]}, {24'd0, ref_pt[exp_w-1]});

        // Wrong key, no early abort
        for (int a = 0; a < 10; a++) ct_mem[1][a] = ct_key[a];
        key1 = 24'h4B6578;
        base = wr_cnt[1];
        run(1, 1'b0, cyc);
        check("bad_full_ok",     {31'd0, key_ok[1]}, {31'd0, fb == 0});
        check("bad_full_writes", 32'(wr_cnt[1] - base), 32'd10);
        check("bad_full_cycles", 32'(cyc), 32'd1337);
        check("bad_full_pt9",    {24'd0, pt_mem[1][9]}, {24'd0, ref_pt[9]});

        // Zero-length message
        ct_mem[1][0] = 8'h00;
        key1 = 24'h4B6579;
        base = wr_cnt[1];
        run(1, 1'b0, cyc);
        check("len0_cycles", 32'(cyc), 32'd1283);
        check("len0_writes", 32'(wr_cnt[1] - base), 32'd1);
        check("len0_pt0",    {24'd0, pt_mem[1][0]}, 32'h00);
        check("len0_ok",     {31'd0, key_ok[1]}, 32'd1);

        // Reset mid-KSA, then a clean run with busy-time en and key noise
        key0 = 24'h123456;
        @(negedge clk);
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (600) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rdy",    {31'd0, rdy[0]},    32'd1);
        check("midrst_key_ok", {31'd0, key_ok[0]}, 32'd0);
        check("midrst_wren",   {31'd0, pt_we[0]},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        key0 = 24'h4B6579;
        base = wr_cnt[0];
        run(0, 1'b1, cyc);
        check("rerun_cycles", 32'(cyc), 32'd1337);
        check("rerun_ok",     {31'd0, key_ok[0]}, 32'd1);
        check("rerun_writes", 32'(wr_cnt[0] - base), 32'd10);
        for (int a = 1; a < 10; a++) check("rerun_pt", {24'd0, pt_mem[0][a]}, {24'd0, s_plain[a-1]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
